// File: rtl/reg_spill_fill_if.sv
// Engine-side bundle: control handshake, register-file port and data-memory port.
interface reg_spill_fill_if #(
  parameter int unsigned pw = 4,
  parameter int unsigned AW = 8
);
  logic          Start;
  logic          Mode;
  logic [AW-1:0] Base;
  logic [pw:0]   Count;
  logic          Busy;
  logic          Done;
  logic [pw:0]   RegAddr;
  logic [7:0]    RegData;
  logic [7:0]    RegDatOut;
  logic          RegWrite;
  logic          AccWrite;
  logic          ImmVal;
  logic [AW-1:0] MemAddr;
  logic          MemWrite;
  logic [7:0]    MemDatOut;
  logic [7:0]    MemDatIn;

  modport master (
    input  Start, Mode, Base, Count, RegData, MemDatIn,
    output Busy, Done, RegAddr, RegDatOut, RegWrite, AccWrite, ImmVal,
           MemAddr, MemWrite, MemDatOut
  );

  modport slave (
    output Start, Mode, Base, Count, RegData, MemDatIn,
    input  Busy, Done, RegAddr, RegDatOut, RegWrite, AccWrite, ImmVal,
           MemAddr, MemWrite, MemDatOut
  );
endinterface

// File: rtl/reg_spill_fill.sv
// Register-file context save/restore engine: spills registers 0..Count-1 to
// memory at Base.. or fills them back, owning the register-file port while busy.
module reg_spill_fill #(
  parameter int unsigned pw   = 4,
  parameter int unsigned NREG = 16,
  parameter int unsigned AW   = 8
) (
  input  logic clk,
  input  logic Reset,
  reg_spill_fill_if.master bus
);
  localparam int unsigned CW = pw + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SPILL     = 3'd1,
    FILL      = 3'd2,
    FILL_TAIL = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] index;
  logic [CW-1:0] count_q;
  logic [AW-1:0] base_q;
  logic [CW-1:0] count_clamp;
  logic [CW-1:0] last_idx;
  logic [CW-1:0] wr_idx;
  logic [AW-1:0] mem_addr;

  assign count_clamp = (bus.Count > CW'(NREG)) ? CW'(NREG) : bus.Count;
  assign last_idx    = count_q - CW'(1);
  // Fill write stage trails the read-issue stage by one register.
  assign wr_idx      = index - CW'(1);
  assign mem_addr    = base_q + AW'(index);

  // State and operand registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state   <= IDLE;
      index   <= '0;
      count_q <= '0;
      base_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            index   <= '0;
            count_q <= count_clamp;
            base_q  <= bus.Base;
          end
        end
        SPILL, FILL: index <= index + CW'(1);
        default: ;
      endcase
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          if (count_clamp == '0) state_nxt = DONE;
          else if (bus.Mode)     state_nxt = FILL;
          else                   state_nxt = SPILL;
        end
      end
      SPILL:     if (index == last_idx) state_nxt = DONE;
      FILL:      if (index == last_idx) state_nxt = FILL_TAIL;
      FILL_TAIL: state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    bus.Busy      = (state != IDLE);
    bus.Done      = (state == DONE);
    bus.RegAddr   = '0;
    bus.RegDatOut = '0;
    bus.RegWrite  = 1'b0;
    bus.AccWrite  = 1'b0;
    bus.ImmVal    = 1'b0;
    bus.MemAddr   = '0;
    bus.MemWrite  = 1'b0;
    bus.MemDatOut = '0;
    case (state)
      SPILL: begin
        bus.RegAddr   = index;
        bus.MemAddr   = mem_addr;
        bus.MemDatOut = bus.RegData;
        bus.MemWrite  = 1'b1;
      end
      FILL, FILL_TAIL: begin
        if (state == FILL) bus.MemAddr = mem_addr;
        if (state == FILL_TAIL || index != '0) begin
          bus.RegAddr   = wr_idx;
          bus.RegDatOut = bus.MemDatIn;
          bus.AccWrite  = (wr_idx == '0);
          bus.RegWrite  = (wr_idx != '0);
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_reg_spill_fill.sv
// Bench for reg_spill_fill: register file and synchronous-read memory models,
// array-level reference of each transfer, directed corners plus random ops.
module tb_reg_spill_fill;
  localparam int unsigned PW   = 4;
  localparam int unsigned AW   = 8;
  localparam int unsigned NREG = 16;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  reg_spill_fill_if #(.pw(PW), .AW(AW)) bus ();
  reg_spill_fill #(.pw(PW), .NREG(NREG), .AW(AW)) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  logic [7:0] mem   [256];
  logic [7:0] rf    [16];
  logic [7:0] m_mem [256];
  logic [7:0] m_rf  [16];
  logic [7:0] mem_rd;
  logic       preload;
  logic       mon_clr;
  int n_memw, n_regw, n_accw, n_bad, n_done;
  logic [7:0] acc_data;
  int tests = 0;
  int fails = 0;

  assign bus.RegData  = rf[bus.RegAddr[PW-1:0]];
  assign bus.MemDatIn = mem_rd;

  // Environment: register file (comb read) and data memory (1-cycle read).
  always @(posedge clk) begin
    if (preload) begin
      mem <= m_mem;
      rf  <= m_rf;
    end else begin
      if (bus.MemWrite) mem[bus.MemAddr] <= bus.MemDatOut;
      if (bus.RegWrite || bus.AccWrite) rf[bus.RegAddr[PW-1:0]] <= bus.RegDatOut;
    end
    mem_rd <= mem[bus.MemAddr];
  end

  // Strobe monitor.
  always @(posedge clk) begin
    if (mon_clr) begin
      n_memw <= 0; n_regw <= 0; n_accw <= 0; n_bad <= 0; n_done <= 0;
      acc_data <= 8'h00;
    end else begin
      if (bus.MemWrite) n_memw <= n_memw + 1;
      if (bus.RegWrite) n_regw <= n_regw + 1;
      if (bus.AccWrite) begin
        n_accw   <= n_accw + 1;
        acc_data <= bus.RegDatOut;
      end
      if (bus.Done) n_done <= n_done + 1;
      n_bad <= n_bad + int'(bus.RegWrite && bus.RegAddr == '0)
                     + int'(bus.AccWrite && bus.RegAddr != '0)
                     + int'(bus.RegWrite && bus.AccWrite)
                     + int'(bus.ImmVal);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({bus.Busy, bus.Done, bus.RegWrite, bus.AccWrite, bus.MemWrite, bus.ImmVal,
                bus.RegAddr, bus.RegDatOut, bus.MemAddr, bus.MemDatOut});
  endfunction

  function automatic int exp_n(input logic [4:0] c);
    return (c > 5'd16) ? 16 : int'(c);
  endfunction

  task automatic do_preload();
    @(negedge clk); preload = 1'b1;
    @(negedge clk); preload = 1'b0;
  endtask

  task automatic load_random();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++)  m_rf[i]  = 8'($urandom);
    do_preload();
  endtask

  // Reference: whole-range copy between the two arrays.
  task automatic model_op(input logic m, input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      if (m) m_rf[i] = m_mem[8'(int'(b) + i)];
      else   m_mem[8'(int'(b) + i)] = m_rf[i];
    end
  endtask

  task automatic check_images(input string tag);
    int nb_m, nb_r;
    nb_m = 0; nb_r = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) nb_m++;
    for (int i = 0; i < 16; i++)  if (rf[i] !== m_rf[i])   nb_r++;
    check({tag, "_mem_img"}, 64'(nb_m), 64'd0);
    check({tag, "_rf_img"},  64'(nb_r), 64'd0);
  endtask

  task automatic start_op(input logic m, input logic [7:0] b, input logic [4:0] c);
    @(negedge clk);
    bus.Start = 1'b1; bus.Mode = m; bus.Base = b; bus.Count = c; mon_clr = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic m, input logic [7:0] b,
                        input logic [4:0] c, input int poke);
    int n, cyc, exp_cyc;
    n = exp_n(c);
    start_op(m, b, c);
    cyc = 1;
    while (bus.Done !== 1'b1 && cyc < 200) begin
      if (cyc == poke) begin
        bus.Start = 1'b1; bus.Mode = ~m; bus.Base = 8'h00; bus.Count = 5'd3;
      end
      @(negedge clk);
      bus.Start = 1'b0;
      cyc++;
    end
    exp_cyc = (n == 0) ? 1 : (m ? n + 2 : n + 1);
    check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_busy_at_done"}, 64'(bus.Busy), 64'd1);
    @(negedge clk);
    check({tag, "_busy_after"}, 64'(bus.Busy), 64'd0);
    check({tag, "_done_pulses"}, 64'(n_done), 64'd1);
    model_op(m, b, n);
    check({tag, "_memwrites"}, 64'(n_memw), m ? 64'd0 : 64'(n));
    check({tag, "_regwrites"}, 64'(n_regw + n_accw), m ? 64'(n) : 64'd0);
    check({tag, "_accwrites"}, 64'(n_accw), (m && n > 0) ? 64'd1 : 64'd0);
    check({tag, "_strobe_rules"}, 64'(n_bad), 64'd0);
    check_images(tag);
  endtask

  initial begin
    Reset = 1'b1; preload = 1'b0; mon_clr = 1'b1;
    bus.Start = 1'b0; bus.Mode = 1'b0; bus.Base = '0; bus.Count = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 64'd0);
    Reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", out_vec(), 64'd0);

    // Spill full file.
    for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++)  m_rf[i]  = 8'(8'h10 + i);
    do_preload();
    run_op("spill16", 1'b0, 8'h40, 5'd16, -1);
    check("spill16_mem4f", 64'(mem[8'h4F]), 64'h1F);

    // Fill full file.
    for (int i = 0; i < 16; i++) m_mem[8'h80 + i] = 8'(8'hA0 + i);
    for (int i = 0; i < 16; i++) m_rf[i] = 8'($urandom);
    do_preload();
    run_op("fill16", 1'b1, 8'h80, 5'd16, -1);
    check("fill16_acc_data", 64'(acc_data), 64'hA0);
    check("fill16_r15", 64'(rf[15]), 64'hAF);

    // Address wrap with partial count.
    load_random();
    run_op("wrap", 1'b0, 8'hFE, 5'd4, -1);

    // Count corners.
    run_op("cnt0_spill", 1'b0, 8'h10, 5'd0, -1);
    run_op("cnt0_fill",  1'b1, 8'h10, 5'd0, -1);
    load_random();
    run_op("cnt20_fill", 1'b1, 8'h33, 5'd20, -1);
    run_op("cnt20_spill", 1'b0, 8'hC5, 5'd20, -1);

    // Start while busy is ignored.
    load_random();
    run_op("start_busy", 1'b0, 8'h20, 5'd8, 3);

    // Reset after three fill writes have landed.
    load_random();
    start_op(1'b1, 8'h80, 5'd16);
    repeat (3) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    check("rst_mid_outputs", out_vec(), 64'd0);
    model_op(1'b1, 8'h80, 3);
    repeat (4) @(negedge clk);
    check("rst_mid_no_done", 64'(n_done), 64'd0);
    check_images("rst_mid");
    run_op("after_rst", 1'b1, 8'h80, 5'd16, -1);

    // Random operations.
    for (int k = 0; k < 12; k++) begin
      logic       rm;
      logic [7:0] rb;
      logic [4:0] rc;
      rm = 1'($urandom);
      rb = 8'($urandom);
      rc = 5'($urandom_range(0, 20));
      load_random();
      run_op($sformatf("rand%0d", k), rm, rb, rc, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_spill_fill.md
Name: reg_spill_fill

Overview:
- Context save/restore engine for the accumulator register file.
- Spill mode reads registers 0..Count-1 through the register file's combinational read port and writes them to data memory at Base..Base+Count-1.
- Fill mode reads the same memory range and writes the bytes back into the register file. Register 0 (the accumulator) is written through the accumulator write strobe.
- Sits beside the core's control unit and owns the register-file address, data and write-enable path while Busy is high.

Parameters:
pw, 4, register address pointer width; the register file holds 2**pw registers.
NREG, 16, maximum registers transferred; must be ≤ 2**pw.
AW, 8, data memory address width.

Ports:
clk  input  1  clock
Reset  input  1  synchronous, active-high reset
Start  input  1  begin an operation; sampled only in IDLE
Mode  input  1  0 = spill (reg→mem), 1 = fill (mem→reg); captured on Start
Base  input  AW  memory base address; captured on Start
Count  input  pw+1  number of registers to move; captured on Start
Busy  output  1  high from the cycle after an accepted Start through the Done cycle
Done  output  1  one-cycle completion pulse
RegAddr  output  pw+1  drives the register file address
RegData  input  8  register file read data
RegDatOut  output  8  drives the register file data input
RegWrite  output  1  register write strobe (indices 1..Count-1)
AccWrite  output  1  accumulator write strobe (index 0 only)
ImmVal  output  1  immediate select to the register file; held 0
MemAddr  output  AW  data memory address
MemWrite  output  1  data memory write strobe
MemDatOut  output  8  data memory write data
MemDatIn  input  8  data memory read data; valid one cycle after MemAddr is presented

Behaviour:
- Reset (synchronous): state=IDLE, index=0. All outputs 0: Busy, Done, RegWrite, AccWrite, MemWrite, RegAddr, RegDatOut, MemAddr, MemDatOut.
- Reset mid-operation: abort at that edge, no Done pulse. Strobes are low in the following cycle. A partially transferred range stays as written.
- Count capture: Count > NREG is clamped to NREG. Count = 0 goes IDLE→DONE with no memory or register accesses.
- States: IDLE, SPILL, FILL, FILL_TAIL, DONE.
- IDLE:
  - On Start, capture Mode, Base and Count (clamped), set index=0, go to SPILL or FILL.
  - Start while not IDLE is ignored.
- SPILL (combinational-read path, one register per cycle):
  - RegAddr=index, MemAddr=Base+index, MemDatOut=RegData, MemWrite=1.
  - index increments each cycle.
  - After the index=Count-1 cycle, go to DONE.
  - Total: Count cycles in SPILL.
- FILL (one-cycle read latency, two-stage pipeline):
  - Cycle k presents MemAddr=Base+k.
  - Cycle k+1 writes register k: RegAddr=k, RegDatOut=MemDatIn. AccWrite=1 when k=0, otherwise RegWrite=1.
  - AccWrite and RegWrite are never high together.
  - The issue of address k+1 overlaps the write of register k.
  - After issuing Count-1, go to FILL_TAIL. FILL_TAIL performs the last write, then goes to DONE.
  - Total: Count+1 cycles.
- DONE: Done=1 for exactly one cycle, strobes low, then IDLE. Busy drops in the cycle after DONE.
- Address arithmetic: Base+index wraps modulo 2**AW. Example: Base=0xFE, Count=4 → 0xFE, 0xFF, 0x00, 0x01.
- Width rules:
  - Index is pw+1 bits wide so index=NREG is representable.
  - RegAddr is zero-extended into the register file's pw+1-bit address.
- Idle outputs: ImmVal=0 always. MemWrite, RegWrite and AccWrite are 0 outside SPILL, FILL and FILL_TAIL.
- Throughput: a new Start is accepted no earlier than the first IDLE cycle after DONE.

Test Plan:
- Spill full file:
  - Stimulus: registers preloaded r[i]=0x10+i; Start, Mode=0, Base=0x40, Count=16.
  - Response: 16 consecutive MemWrite cycles, mem[0x40+i]=0x10+i; Done 17 cycles after Start accepted.
- Fill full file:
  - Stimulus: mem[0x80+i]=0xA0+i; Start, Mode=1, Base=0x80, Count=16.
  - Response: AccWrite only on the write to register 0 with 0xA0; RegWrite for registers 1..15; r[15]=0xAF; Done in cycle 18.
- Wrap and partial count:
  - Stimulus: spill with Base=0xFE, Count=4.
  - Response: writes to 0xFE, 0xFF, 0x00, 0x01 only; memory at 0x02 untouched.
- Count corner cases:
  - Count=0 → Done one cycle after Start, no strobes.
  - Count=20 → behaves as Count=16.
- Start while Busy:
  - Stimulus: second Start with Mode=1 during a spill.
  - Response: ignored; spill completes unchanged; exactly one Done.
- Reset mid-fill:
  - Stimulus: assert Reset after 3 registers are written.
  - Response: next cycle Busy=0 and all strobes 0; no Done pulse; registers 0..2 updated, 3..15 unchanged; a new Start then works normally.
